// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared encodings and width helpers for the CPU bus-interface unit
package cpu_bus_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Fill bit replicated across the data bus when a transfer is aborted.
  localparam logic OPEN_BUS = 1'b1;

  // Width of a counter that must hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Width of a channel index for n channels, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_bus_unit_rr_arbiter.sv
// rtl/cpu_bus_unit_rr_arbiter.sv - round-robin request arbiter with its own pointer register
module rr_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             req_i,
  input  logic                          accept_i,
  output logic [NUM_CH-1:0]             grant_o,
  output logic [idx_width(NUM_CH)-1:0]  idx_o,
  output logic                          any_o
);

  localparam int IW = idx_width(NUM_CH);

  logic [IW-1:0] ptr_q;

  // Pointer remembers the last winner; reset to the top channel so ch0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IW'(NUM_CH - 1);
    end else if (accept_i && any_o) begin
      ptr_q <= idx_o;
    end
  end

  // Scan channels starting just after the pointer, wrapping, and take the first requester.
  always_comb begin
    int c;
    c       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(ptr_q) + k) % NUM_CH;
      if (!any_o && req_i[c]) begin
        any_o      = 1'b1;
        grant_o[c] = 1'b1;
        idx_o      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/cpu_bus_unit.sv
// rtl/cpu_bus_unit.sv - arbitrated memory bus interface with wait states and stall timeout
module cpu_bus_unit
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int NUM_CH      = 2,
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        done,
  output logic                     err,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        address,
  output logic                     read_write,
  output logic [DATA_W-1:0]        data_write,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        data_read
);

  localparam int IW = idx_width(NUM_CH);
  localparam int WW = cnt_width(WAIT_STATES);
  localparam int TW = cnt_width(TIMEOUT);

  state_e              state_q;
  logic [NUM_CH-1:0]   win_oh_q;
  logic [NUM_CH-1:0]   gnt_q;
  logic [NUM_CH-1:0]   done_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                mem_valid_q;
  logic [WW-1:0]       wait_q;
  logic [TW-1:0]       tmo_q;

  logic [NUM_CH-1:0]   arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic                accept;

  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we;

  logic                wait_over;
  logic                complete;
  logic                timed_out;

  assign accept = (state_q == ST_IDLE) && arb_any;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .accept_i (accept),
    .grant_o  (arb_grant),
    .idx_o    (arb_idx),
    .any_o    (arb_any)
  );

  assign sel_addr  = addr[int'(arb_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = wdata[int'(arb_idx)*DATA_W +: DATA_W];
  assign sel_we    = we[arb_idx];

  // mem_ready only counts once the fixed wait cycles are used up; the timeout fires on the
  // last allowed ACCESS cycle and loses to a completion in that same cycle.
  assign wait_over = (int'(wait_q) >= WAIT_STATES);
  assign complete  = wait_over && mem_ready;
  assign timed_out = (TIMEOUT != 0) && (int'(tmo_q) >= TIMEOUT - 1);

  // Transfer FSM with all bus-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      win_oh_q    <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      rw_q        <= RW_READ;
      wdata_q     <= '0;
      mem_valid_q <= 1'b0;
      wait_q      <= '0;
      tmo_q       <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            state_q     <= ST_ACCESS;
            win_oh_q    <= arb_grant;
            gnt_q       <= arb_grant;
            addr_q      <= sel_addr;
            rw_q        <= sel_we ? RW_WRITE : RW_READ;
            wdata_q     <= sel_wdata;
            mem_valid_q <= 1'b1;
            wait_q      <= '0;
            tmo_q       <= '0;
          end
        end
        ST_ACCESS: begin
          if (complete) begin
            if (rw_q == RW_READ) begin
              rdata_q <= data_read;
            end
            done_q      <= win_oh_q;
            mem_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (timed_out) begin
            rdata_q     <= {DATA_W{OPEN_BUS}};
            done_q      <= win_oh_q;
            err_q       <= 1'b1;
            mem_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            if (!wait_over) begin
              wait_q <= wait_q + WW'(1);
            end
            if (int'(tmo_q) < TIMEOUT) begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign address    = addr_q;
  assign read_write = rw_q;
  assign data_write = wdata_q;
  assign mem_valid  = mem_valid_q;

endmodule

// File: tb/tb_cpu_bus_unit.sv
// tb/tb_cpu_bus_unit.sv - scoreboard bench for cpu_bus_unit with zero- and two-wait-state instances
module tb_cpu_bus_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  a_req = '0;
  logic [1:0]  b_req = '0;
  logic [1:0]  we = '0;
  logic [31:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        mem_ready = 1'b0;
  logic [7:0]  data_read = '0;

  logic [1:0]  a_gnt, a_done, b_gnt, b_done;
  logic        a_err, a_rw, a_mv, b_err, b_rw, b_mv;
  logic [7:0]  a_rdata, a_dw, b_rdata, b_dw;
  logic [15:0] a_addr, b_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         ch;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  cpu_bus_unit #(.ADDR_W(16), .DATA_W(8), .NUM_CH(2), .WAIT_STATES(0), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .req(a_req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(a_gnt), .done(a_done), .err(a_err), .rdata(a_rdata), .address(a_addr),
    .read_write(a_rw), .data_write(a_dw), .mem_valid(a_mv),
    .mem_ready(mem_ready), .data_read(data_read)
  );

  cpu_bus_unit #(.ADDR_W(16), .DATA_W(8), .NUM_CH(2), .WAIT_STATES(2), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(b_gnt), .done(b_done), .err(b_err), .rdata(b_rdata), .address(b_addr),
    .read_write(b_rw), .data_write(b_dw), .mem_valid(b_mv),
    .mem_ready(mem_ready), .data_read(data_read)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Every done pulse is matched against the oldest predicted completion.
  always @(negedge clk) begin
    if (a_done != 2'b00) begin
      if (q_a.size() == 0) begin
        check("a_done_unexpected", 32'(a_done), 32'd0);
      end else begin
        ea = q_a.pop_front();
        check("a_done_ch", 32'(a_done), 32'd1 << ea.ch);
        check("a_err", 32'(a_err), 32'(ea.err));
        check("a_rdata", 32'(a_rdata), 32'(ea.rdata));
      end
    end
    if (b_done != 2'b00) begin
      if (q_b.size() == 0) begin
        check("b_done_unexpected", 32'(b_done), 32'd0);
      end else begin
        eb = q_b.pop_front();
        check("b_done_ch", 32'(b_done), 32'd1 << eb.ch);
        check("b_err", 32'(b_err), 32'(eb.err));
        check("b_rdata", 32'(b_rdata), 32'(eb.rdata));
      end
    end
  end

  task automatic reset_all();
    rst = 1'b1;
    a_req = '0; b_req = '0; we = '0; addr = '0; wdata = '0;
    mem_ready = 1'b0; data_read = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_a(input int ch, input logic e, input logic [7:0] rd);
    exp_t x;
    x.ch = ch; x.err = e; x.rdata = rd;
    q_a.push_back(x);
  endtask

  task automatic push_b(input int ch, input logic e, input logic [7:0] rd);
    exp_t x;
    x.ch = ch; x.err = e; x.rdata = rd;
    q_b.push_back(x);
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_gnt"}, 32'(a_gnt), 32'd0);
    check({tag, "_done"}, 32'(a_done), 32'd0);
    check({tag, "_err"}, 32'(a_err), 32'd0);
    check({tag, "_rdata"}, 32'(a_rdata), 32'd0);
    check({tag, "_address"}, 32'(a_addr), 32'd0);
    check({tag, "_rw"}, 32'(a_rw), 32'd1);
    check({tag, "_dw"}, 32'(a_dw), 32'd0);
    check({tag, "_mv"}, 32'(a_mv), 32'd0);
  endtask

  // One transfer on the two-wait-state instance with mem_ready held high.
  task automatic b_xfer(input int ch, input logic w, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] dr, input logic [7:0] exp_rd);
    push_b(ch, 1'b0, exp_rd);
    mem_ready = 1'b1; data_read = dr;
    we = '0; we[ch] = w;
    addr[ch*16 +: 16] = a;
    wdata[ch*8 +: 8] = d;
    b_req = '0; b_req[ch] = 1'b1;
    @(negedge clk);
    check("b_gnt", 32'(b_gnt), 32'd1 << ch);
    b_req = '0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("b_mv_access", 32'(b_mv), 32'd1);
      check("b_no_early_done", 32'(b_done), 32'd0);
      check("b_rw", 32'(b_rw), 32'(!w));
      check("b_address", 32'(b_addr), 32'(a));
      if (w) check("b_data_write", 32'(b_dw), 32'(d));
    end
    @(negedge clk);
    check("b_mv_after", 32'(b_mv), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset_all();
    check_a_reset("rst");

    // Single zero-wait read on ch0
    push_a(0, 1'b0, 8'hA5);
    a_req = 2'b01; addr[15:0] = 16'h1234; mem_ready = 1'b1; data_read = 8'hA5;
    @(negedge clk);
    check("t1_gnt", 32'(a_gnt), 32'd1);
    check("t1_mv", 32'(a_mv), 32'd1);
    check("t1_address", 32'(a_addr), 32'h1234);
    check("t1_rw", 32'(a_rw), 32'd1);
    a_req = '0;
    @(negedge clk);
    check("t1_mv_drop", 32'(a_mv), 32'd0);
    check("t1_gnt_pulse", 32'(a_gnt), 32'd0);
    check("t1_addr_hold", 32'(a_addr), 32'h1234);
    @(negedge clk);
    check("t1_mv_idle", 32'(a_mv), 32'd0);
    check("t1_rdata_held", 32'(a_rdata), 32'hA5);

    // Both channels request continuously: grants alternate
    reset_all();
    data_read = 8'h5A; mem_ready = 1'b1;
    addr = {16'h0200, 16'h0100};
    for (int g = 0; g < 4; g++) push_a(g % 2, 1'b0, 8'h5A);
    a_req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check("t2_gnt", 32'(a_gnt), 32'd1 << (g % 2));
      check("t2_mv", 32'(a_mv), 32'd1);
      check("t2_address", 32'(a_addr), (g % 2) ? 32'h0200 : 32'h0100);
      @(negedge clk);
      check("t2_gap", 32'(a_mv), 32'd0);
      check("t2_gnt_gap", 32'(a_gnt), 32'd0);
      if (g == 3) a_req = '0;
    end

    // Two wait states: read then write, write leaves rdata alone
    reset_all();
    b_xfer(0, 1'b0, 16'h0010, 8'h00, 8'h77, 8'h77);
    b_xfer(1, 1'b1, 16'h00FF, 8'h3C, 8'h00, 8'h77);

    // Timeout after four stalled cycles, then a normal transfer
    push_a(0, 1'b1, 8'hFF);
    mem_ready = 1'b0; we = '0; data_read = 8'h11;
    a_req = 2'b01;
    @(negedge clk);
    check("t4_gnt", 32'(a_gnt), 32'd1);
    a_req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_mv_stall", 32'(a_mv), 32'd1);
      check("t4_no_done", 32'(a_done), 32'd0);
    end
    @(negedge clk);
    check("t4_mv_abort", 32'(a_mv), 32'd0);
    push_a(1, 1'b0, 8'h42);
    mem_ready = 1'b1; data_read = 8'h42; a_req = 2'b10;
    @(negedge clk);
    check("t4_next_gnt", 32'(a_gnt), 32'd2);
    a_req = '0;
    @(negedge clk);
    check("t4_next_mv", 32'(a_mv), 32'd0);

    // Completion in the last allowed cycle beats the timeout
    push_a(0, 1'b0, 8'h99);
    mem_ready = 1'b0; data_read = 8'h99; a_req = 2'b01;
    @(negedge clk);
    a_req = '0;
    repeat (3) @(negedge clk);
    check("t4b_still_busy", 32'(a_mv), 32'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    check("t4b_mv_end", 32'(a_mv), 32'd0);
    mem_ready = 1'b0;

    // Reset during a stalled write aborts silently
    we = 2'b01; addr[15:0] = 16'hBEEF; wdata[7:0] = 8'h5C; a_req = 2'b01;
    @(negedge clk);
    check("t5_gnt", 32'(a_gnt), 32'd1);
    check("t5_rw_write", 32'(a_rw), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_a_reset("t5_rst");
    rst = 1'b0;
    we = '0; mem_ready = 1'b1; data_read = 8'h31;
    push_a(0, 1'b0, 8'h31);
    push_a(1, 1'b0, 8'h31);
    a_req = 2'b11;
    @(negedge clk);
    check("t5_ch0_first", 32'(a_gnt), 32'd1);
    a_req = 2'b10;
    @(negedge clk);
    check("t5_gap", 32'(a_mv), 32'd0);
    @(negedge clk);
    check("t5_ch1_next", 32'(a_gnt), 32'd2);
    a_req = '0;
    @(negedge clk);

    // Glitched requests and idle mem_ready pulses start nothing
    @(negedge clk);
    a_req = 2'b01; b_req = 2'b10; mem_ready = 1'b1;
    #2;
    a_req = '0; b_req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = (i % 2 == 0) ? 1'b0 : 1'b1;
      check("t6_a_gnt", 32'(a_gnt), 32'd0);
      check("t6_a_mv", 32'(a_mv), 32'd0);
      check("t6_b_gnt", 32'(b_gnt), 32'd0);
      check("t6_b_mv", 32'(b_mv), 32'd0);
    end

    repeat (2) @(negedge clk);
    check("a_sb_empty", 32'(q_a.size()), 32'd0);
    check("b_sb_empty", 32'(q_b.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
